// File: rtl/onewire_master.sv
// Byte-level 1-Wire bus master, standard speed.
// Generates reset/presence, write and read time slots on an open-drain line.
// Commands come in on a valid/ready port; results go out on a valid/ready
// response port. All slot timing comes from a microsecond prescaler.
module onewire_master #(
  parameter int CLK_PER_US = 100
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       rsp_err,
  input  logic       W_IN,
  output logic       W_OUT
);

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    RST_REL,
    SLOT_LOW,
    SLOT_REL,
    RESP
  } state_t;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int              PW       = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_PER_US - 1);

  // Phase lengths and sample instants, in microseconds.
  localparam logic [9:0] RESET_US     = 10'd480;
  localparam logic [9:0] SLOT_US      = 10'd70;
  localparam logic [9:0] SHORT_LOW_US = 10'd6;
  localparam logic [9:0] LONG_LOW_US  = 10'd60;
  // Presence sampled at 70 us into the release phase (edge ending us 69).
  localparam logic [9:0] PRES_SAMPLE  = 10'd69;
  // Read sampled 15 us from slot start: 6 us low + 9 us into release.
  localparam logic [9:0] READ_SAMPLE  = 10'd8;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] pre;
  logic [9:0]    us_cnt;
  logic [2:0]    slot_cnt;
  logic [7:0]    shreg;
  logic [1:0]    op_q;
  logic          w_in_s1;
  logic          w_in_s2;
  logic          pres_sample;
  logic          read_bit;

  logic          tick;
  logic          timed;
  logic          is_read;
  logic [9:0]    low_us;
  logic [9:0]    phase_us;
  logic          phase_done;
  logic          accept;
  logic          load_rsp;
  logic [7:0]    shreg_next;
  logic [7:0]    rsp_data_d;
  logic          rsp_presence_d;
  logic          rsp_err_d;

  // A new command is only taken when idle and no response is outstanding.
  assign cmd_ready = (state == IDLE) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;

  // Phase length of the current timed state and its terminal condition.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (which would infer a latch).
    phase_us = 10'd0;
    timed    = 1'b0;
    tick     = (pre == PRE_LAST);
    is_read  = (op_q == OP_READ);
    // Reads and write-1 slots use the short low pulse.
    low_us   = (is_read || shreg[0]) ? SHORT_LOW_US : LONG_LOW_US;
    case (state)
      RST_LOW, RST_REL: begin
        phase_us = RESET_US;
        timed    = 1'b1;
      end
      SLOT_LOW: begin
        phase_us = low_us;
        timed    = 1'b1;
      end
      SLOT_REL: begin
        phase_us = SLOT_US - low_us;
        timed    = 1'b1;
      end
      default: ;
    endcase
    phase_done = timed && tick && (us_cnt == phase_us - 10'd1);
    // Writes rotate so the byte comes back as the echo; reads shift in the sample.
    shreg_next = {(is_read ? read_bit : shreg[0]), shreg[7:1]};
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state <= state_next;
    end
  end

  // Next-state logic and response field selection.
  always_comb begin
    state_next     = state;
    rsp_data_d     = 8'h00;
    rsp_presence_d = 1'b0;
    rsp_err_d      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_RESET: state_next = RST_LOW;
            OP_WRITE,
            OP_READ:  state_next = SLOT_LOW;
            default:  state_next = RESP;
          endcase
        end
        // The only IDLE-to-RESP path is the reserved op.
        rsp_err_d = 1'b1;
      end
      RST_LOW: begin
        if (phase_done) state_next = RST_REL;
      end
      RST_REL: begin
        if (phase_done) state_next = RESP;
        rsp_presence_d = ~pres_sample;
      end
      SLOT_LOW: begin
        if (phase_done) state_next = SLOT_REL;
      end
      SLOT_REL: begin
        if (phase_done) state_next = (slot_cnt == 3'd7) ? RESP : SLOT_LOW;
        rsp_data_d = shreg_next;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    load_rsp = (state_next == RESP) && (state != RESP);
  end

  // Microsecond prescaler and us counter, cleared on every state entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre    <= '0;
      us_cnt <= '0;
    end else if (state_next != state) begin
      pre    <= '0;
      us_cnt <= '0;
    end else if (timed) begin
      if (tick) begin
        pre    <= '0;
        us_cnt <= us_cnt + 10'd1;
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

  // Two-flop synchroniser for the asynchronous bus level; idle bus reads high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      w_in_s1 <= 1'b1;
      w_in_s2 <= 1'b1;
    end else begin
      w_in_s1 <= W_IN;
      w_in_s2 <= w_in_s1;
    end
  end

  // Command capture, slot sequencing and bus sampling.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q        <= OP_RESET;
      shreg       <= 8'h00;
      slot_cnt    <= 3'd0;
      pres_sample <= 1'b1;
      read_bit    <= 1'b1;
    end else begin
      if (accept) begin
        op_q     <= cmd_op;
        shreg    <= (cmd_op == OP_WRITE) ? cmd_data : 8'h00;
        slot_cnt <= 3'd0;
      end
      if (state == RST_REL && tick && us_cnt == PRES_SAMPLE) begin
        pres_sample <= w_in_s2;
      end
      if (state == SLOT_REL && tick && us_cnt == READ_SAMPLE) begin
        read_bit <= w_in_s2;
      end
      if (state == SLOT_REL && phase_done) begin
        shreg    <= shreg_next;
        slot_cnt <= slot_cnt + 3'd1;
      end
    end
  end

  // Response registers: fields load on entry to RESP and hold afterwards;
  // rsp_valid rises the cycle after entry and drops on the handshake.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      rsp_presence <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      if (load_rsp) begin
        rsp_data     <= rsp_data_d;
        rsp_presence <= rsp_presence_d;
        rsp_err      <= rsp_err_d;
      end
      if (state == RESP && !rsp_valid) begin
        rsp_valid <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Registered open-drain drive; the async reset releases the line at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      W_OUT <= 1'b1;
    end else begin
      W_OUT <= !(state == RST_LOW || state == SLOT_LOW);
    end
  end

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master at CLK_PER_US = 4 (1 us = 4 cycles = 40 ns).
// A small slave model answers presence and drives read bits on W_IN.
module tb_onewire_master;

  localparam int CPU = 4;
  localparam int PERIOD = 10;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_presence;
  logic       rsp_err;
  logic       w_in;
  logic       w_out;

  int checks = 0;
  int errors = 0;

  // Slave model controls.
  int         slave_mode = 0;   // 0 none, 1 presence, 2 read responder
  logic       pres_pull = 1'b0;
  logic       rd_pull = 1'b0;
  logic [7:0] rd_byte = 8'h3C;
  logic [2:0] rd_idx = 3'd0;

  // W_OUT low-pulse monitor.
  int  widths [64];
  time falls [64];
  int  pulse_cnt = 0;
  time t_fall = 0;

  assign w_in = ~(pres_pull | rd_pull);

  onewire_master #(.CLK_PER_US(CPU)) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_presence (rsp_presence),
    .rsp_err      (rsp_err),
    .W_IN         (w_in),
    .W_OUT        (w_out)
  );

  initial begin
    clk = 1'b0;
    forever #(PERIOD / 2) clk = ~clk;
  end

  // Record fall time of each low pulse.
  always @(negedge w_out) t_fall = $time;

  // Record width (in cycles) and start time of each completed low pulse.
  always @(posedge w_out) begin
    if (pulse_cnt < 64) begin
      widths[pulse_cnt] = int'(($time - t_fall) / PERIOD);
      falls[pulse_cnt]  = t_fall;
    end
    pulse_cnt++;
  end

  // Presence responder: pulls low from 20 us to 140 us after release.
  always @(posedge w_out) begin
    if (slave_mode == 1) begin
      #(20 * CPU * PERIOD);
      pres_pull = 1'b1;
      #(120 * CPU * PERIOD);
      pres_pull = 1'b0;
    end
  end

  // Read responder: holds the line low 0-30 us of each slot carrying a 0 bit.
  always @(negedge w_out) begin
    if (slave_mode == 2) begin
      if (!rd_byte[rd_idx]) begin
        rd_pull = 1'b1;
        #(30 * CPU * PERIOD);
        rd_pull = 1'b0;
      end
      rd_idx = rd_idx + 3'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a command and let it be accepted on the next rising edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    @(negedge clk);
    check("accept_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Count edges after acceptance until rsp_valid is seen (bounded).
  task automatic wait_rsp(input int limit, output int n);
    n = 0;
    while (!rsp_valid && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Consume the response and check the handshake effect one edge later.
  task automatic take_rsp(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_valid_clr"}, rsp_valid, 1'b0);
    check({tag, "_ready_set"}, cmd_ready, 1'b1);
  endtask

  initial begin
    int n;
    int base;
    int bad;
    logic [7:0] wr_byte;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    rsp_ready = 1'b0;
    wr_byte   = 8'hA5;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_w_out", w_out, 1'b1);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_presence", rsp_presence, 1'b0);
    check("rst_err", rsp_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Op 00 with a slave answering.
    slave_mode = 1;
    base = pulse_cnt;
    issue(2'b00, 8'h00);
    wait_rsp(5000, n);
    check("rp_latency", n, 960 * CPU + 1);
    check("rp_low_width", widths[base], 480 * CPU);
    check("rp_presence", rsp_presence, 1'b1);
    check("rp_data", rsp_data, 8'h00);
    check("rp_err", rsp_err, 1'b0);
    take_rsp("rp");
    slave_mode = 0;

    // Op 00 with no slave.
    issue(2'b00, 8'h00);
    wait_rsp(5000, n);
    check("rp0_latency", n, 960 * CPU + 1);
    check("rp0_presence", rsp_presence, 1'b0);
    take_rsp("rp0");

    // Op 01, write 0xA5, LSB first.
    base = pulse_cnt;
    issue(2'b01, wr_byte);
    wait_rsp(5000, n);
    check("wr_latency", n, 560 * CPU + 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("wr_low_%0d", i), widths[base + i], wr_byte[i] ? 6 * CPU : 60 * CPU);
    end
    for (int i = 0; i < 7; i++) begin
      check($sformatf("wr_pitch_%0d", i), 32'(falls[base + i + 1] - falls[base + i]), 70 * CPU * PERIOD);
    end
    check("wr_echo", rsp_data, 8'hA5);
    check("wr_err", rsp_err, 1'b0);
    take_rsp("wr");

    // Op 10, slave returns 0x3C.
    slave_mode = 2;
    base = pulse_cnt;
    issue(2'b10, 8'hFF);
    wait_rsp(5000, n);
    check("rd_latency", n, 560 * CPU + 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rd_low_%0d", i), widths[base + i], 6 * CPU);
    end
    check("rd_data", rsp_data, 8'h3C);
    take_rsp("rd");
    slave_mode = 0;

    // Op 11 plus back-pressure: response held 50 cycles with a queued command.
    base = pulse_cnt;
    issue(2'b11, 8'h77);
    wait_rsp(100, n);
    check("op11_latency", n, 1);
    check("op11_err", rsp_err, 1'b1);
    check("op11_data", rsp_data, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_data  = 8'h00;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 ||
          rsp_data !== 8'h00 || rsp_presence !== 1'b0 || w_out !== 1'b1) bad++;
    end
    check("hold_stable", bad, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_valid_clr", rsp_valid, 1'b0);
    check("hs_ready_set", cmd_ready, 1'b1);
    @(negedge clk);
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    check("hs_queued_taken", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("hs_queued_rsp", rsp_valid, 1'b1);
    check("hs_queued_err", rsp_err, 1'b1);
    check("op11_no_bus", pulse_cnt - base, 0);
    take_rsp("hs");

    // Reset during the slot-3 low phase of a write.
    issue(2'b01, wr_byte);
    repeat (900) @(posedge clk);
    #3;
    check("mid_slot3_low", w_out, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_release", w_out, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || w_out !== 1'b1) bad++;
    end
    check("no_rsp_after_abort", bad, 0);
    check("abort_ready", cmd_ready, 1'b1);

    // Fresh op 00 after the abort.
    slave_mode = 1;
    base = pulse_cnt;
    issue(2'b00, 8'h00);
    wait_rsp(5000, n);
    check("rp2_latency", n, 960 * CPU + 1);
    check("rp2_low_width", widths[base], 480 * CPU);
    check("rp2_presence", rsp_presence, 1'b1);
    take_rsp("rp2");
    slave_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
